// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment receive path.
// Contents: segment bit indices, the 16 hex glyph patterns (seg[6:0], active-high)
// and the receiver's stability-tracking FSM state type.
package seg_pkg;

    // Segment bit positions within the {dp,g,f,e,d,c,b,a} bus.
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Hex glyphs, {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } seg_rx_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment glyph decoder (combinational).
// Ports:
//   seg   in  7  segment pattern {g,f,e,d,c,b,a}, active-high
//   valid out 1  pattern is one of the 16 hex glyphs
//   hex   out 4  decoded nibble (0 when not valid)
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b1;
        hex   = 4'h0;
        case (seg)
            GLYPH_0: hex = 4'h0;
            GLYPH_1: hex = 4'h1;
            GLYPH_2: hex = 4'h2;
            GLYPH_3: hex = 4'h3;
            GLYPH_4: hex = 4'h4;
            GLYPH_5: hex = 4'h5;
            GLYPH_6: hex = 4'h6;
            GLYPH_7: hex = 4'h7;
            GLYPH_8: hex = 4'h8;
            GLYPH_9: hex = 4'h9;
            GLYPH_A: hex = 4'hA;
            GLYPH_B: hex = 4'hB;
            GLYPH_C: hex = 4'hC;
            GLYPH_D: hex = 4'hD;
            GLYPH_E: hex = 4'hE;
            GLYPH_F: hex = 4'hF;
            // Blank and every other pattern are not hex glyphs.
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive side of the 4-digit multiplexed seven-segment bus.
// Qualifies each sampled {pos,seg} for STABLE_CNT identical samples, decodes
// the glyph and assembles a 4-digit frame; flags bad pos and a frame timeout.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   sample_en         bus is only sampled when high
//   pos[3:0]          one-hot digit select, pos[0] = rightmost
//   seg[7:0]          {dp,g,f,e,d,c,b,a}
//   digits[15:0]      captured nibbles, digits[4i+3:4i] <-> pos[i]
//   dp[3:0]           captured decimal points
//   digit_err[3:0]    last capture of digit i was not a hex glyph
//   pos_err           pulse: sampled pos was multi-hot
//   frame_valid       pulse: all four digits captured
//   timeout           pulse: TIMEOUT cycles without a frame
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic [3:0]  pos,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_err,
    output logic        pos_err,
    output logic        frame_valid,
    output logic        timeout
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seg_rx_state_t state, state_next;
    logic [3:0]    cand_pos, cand_pos_next;
    logic [7:0]    cand_seg, cand_seg_next;
    logic [7:0]    count, count_next;
    logic          capture;
    logic [3:0]    seen, seen_or, cap_mask;
    logic [TW-1:0] tcnt;
    logic          frame_done, tmo_hit;
    logic          pos_zero, pos_multi, same;
    logic          glyph_valid;
    logic [3:0]    glyph_hex;

    assign pos_zero  = (pos == 4'b0000);
    assign pos_multi = ((pos & (pos - 4'd1)) != 4'b0000);
    assign same      = (pos == cand_pos) && (seg == cand_seg);

    seg7_decode u_decode (
        .seg   (seg[6:0]),
        .valid (glyph_valid),
        .hex   (glyph_hex)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand_pos <= 4'b0000;
            cand_seg <= 8'h00;
            count    <= 8'd0;
        end else begin
            state    <= state_next;
            cand_pos <= cand_pos_next;
            cand_seg <= cand_seg_next;
            count    <= count_next;
        end
    end

    // Next-state logic; everything holds when the bus is not sampled.
    always_comb begin
        state_next    = state;
        cand_pos_next = cand_pos;
        cand_seg_next = cand_seg;
        count_next    = count;
        if (sample_en) begin
            if (pos_zero || pos_multi) begin
                state_next = IDLE;
                count_next = 8'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cand_pos_next = pos;
                        cand_seg_next = seg;
                        count_next    = 8'd1;
                        state_next    = TRACK;
                    end
                    TRACK: begin
                        if (same) begin
                            count_next = count + 8'd1;
                            if (count_next == 8'(STABLE_CNT)) state_next = HELD;
                        end else begin
                            cand_pos_next = pos;
                            cand_seg_next = seg;
                            count_next    = 8'd1;
                        end
                    end
                    HELD: begin
                        if (!same) begin
                            cand_pos_next = pos;
                            cand_seg_next = seg;
                            count_next    = 8'd1;
                            state_next    = TRACK;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Output decode: capture fires on the sample that completes the stable run.
    always_comb begin
        capture = sample_en && !pos_zero && !pos_multi && (state == TRACK) && same &&
                  ((count + 8'd1) == 8'(STABLE_CNT));
        cap_mask = capture ? pos : 4'b0000;
    end

    assign seen_or    = seen | cap_mask;
    assign frame_done = (seen_or == 4'hF);
    assign tmo_hit    = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= 16'h0000;
            dp          <= 4'b0000;
            digit_err   <= 4'b0000;
            pos_err     <= 1'b0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
            seen        <= 4'b0000;
            tcnt        <= '0;
        end else begin
            pos_err     <= sample_en && pos_multi;
            frame_valid <= frame_done;
            // A completing frame suppresses a coincident timeout.
            timeout     <= tmo_hit && !frame_done;
            if (frame_done || tmo_hit) begin
                seen <= 4'b0000;
                tcnt <= '0;
            end else begin
                seen <= seen_or;
                tcnt <= tcnt + TW'(1);
            end
            for (int i = 0; i < 4; i++) begin
                if (cap_mask[i]) begin
                    dp[i] <= seg[7];
                    if (glyph_valid) begin
                        digits[4*i +: 4] <= glyph_hex;
                        digit_err[i]     <= 1'b0;
                    end else begin
                        digit_err[i]     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
